// File: rtl/cordic_periph_ctrl_if.sv
// TinyQV peripheral bus bundle for the CORDIC front-end.
// master = CPU side, slave = peripheral side.
interface cordic_periph_ctrl_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/cordic_periph_ctrl.sv
// TinyQV register front-end and start/wait/timeout sequencer for the CORDIC engine.
// Define CORDIC_IRQ_EN to store CTRL.IRQ_EN and drive user_interrupt from DONE.
module cordic_periph_ctrl #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] NAN_RESULT     = 32'h7FC00000
) (
    input  logic                 clk,
    input  logic                 reset,
    cordic_periph_ctrl_if.slave  bus,
    output logic                 user_interrupt,
    output logic [31:0]          eng_dataa,
    output logic                 eng_cos,
    output logic                 eng_start,
    output logic                 eng_clk_en,
    output logic                 eng_reset,
    input  logic                 eng_done,
    input  logic [31:0]          eng_result,
    input  logic                 eng_invalid
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [CW-1:0] cnt;
    logic [31:0]   operand;
    logic [31:0]   result;
    logic          cos, done, invalid, timeout, overrun, irq_en, busy;
    logic          wr, rd_res, wr_op, wr_ctrl;
    logic          srst, clr, start_req, launch;
    logic          timeout_hit, done_hit;

    assign wr      = bus.data_write_n == 2'b10;
    assign wr_op   = wr && bus.address == 6'h00;
    assign wr_ctrl = wr && bus.address == 6'h04;
    assign rd_res  = bus.data_read_n != 2'b11 && bus.address == 6'h0C;

    // SRST takes priority over a START carried in the same write
    assign srst      = wr_ctrl && bus.data_in[3];
    assign clr       = wr_ctrl && bus.data_in[2];
    assign start_req = wr_ctrl && bus.data_in[0] && !srst;
    assign launch    = start_req && !busy && !eng_invalid;

    assign timeout_hit = state == S_WAIT && !eng_done &&
                         cnt == CW'(TIMEOUT_CYCLES - 1);
    assign done_hit    = state == S_WAIT && eng_done && !srst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (launch) state_n = S_START;
            S_START: state_n = S_WAIT;
            S_WAIT:  if (eng_done || timeout_hit) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (srst) state_n = S_IDLE;
    end

    always_comb begin
        busy      = state != S_IDLE;
        eng_start = state == S_START;
    end

    // later assignments win: read/CLR clear first, then START, then engine events, SRST last
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            operand   <= '0;
            result    <= '0;
            cos       <= 1'b0;
            done      <= 1'b0;
            invalid   <= 1'b0;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
            eng_reset <= 1'b0;
        end else begin
            eng_reset <= srst || timeout_hit;
            if (state == S_START)     cnt <= '0;
            else if (state == S_WAIT) cnt <= cnt + CW'(1);
            if (wr_op) begin
                if (busy) overrun <= 1'b1;
                else      operand <= bus.data_in;
            end
            if (rd_res) done <= 1'b0;
            if (clr) begin
                done    <= 1'b0;
                invalid <= 1'b0;
                timeout <= 1'b0;
                overrun <= 1'b0;
            end
            if (start_req) begin
                if (busy) begin
                    overrun <= 1'b1;
                end else begin
                    cos     <= bus.data_in[1];
                    done    <= eng_invalid;
                    invalid <= eng_invalid;
                    timeout <= 1'b0;
                    if (eng_invalid) result <= NAN_RESULT;
                end
            end
            if (timeout_hit) timeout <= 1'b1;
            if (done_hit) begin
                result <= eng_result;
                done   <= 1'b1;
            end
            if (srst) begin
                done    <= 1'b0;
                invalid <= 1'b0;
                timeout <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

`ifdef CORDIC_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        irq_en <= 1'b0;
        else if (wr_ctrl) irq_en <= bus.data_in[4];
    end
    assign user_interrupt = done & irq_en;
`else
    assign irq_en         = 1'b0;
    assign user_interrupt = 1'b0;
`endif

    assign eng_dataa      = operand;
    assign eng_cos        = cos;
    assign eng_clk_en     = 1'b1;
    assign bus.data_ready = 1'b1;

    always_comb begin
        unique case (bus.address)
            6'h00:   bus.data_out = operand;
            6'h04:   bus.data_out = {27'b0, irq_en, 2'b00, cos, 1'b0};
            6'h08:   bus.data_out = {27'b0, overrun, timeout,
                                     invalid, done, busy};
            6'h0C:   bus.data_out = result;
            default: bus.data_out = '0;
        endcase
    end
endmodule

// File: tb/tb_cordic_periph_ctrl.sv
// Randomised bench for cordic_periph_ctrl against a transaction-level model.
// Engine stub: programmable latency, 20 cycles by default.
module tb_cordic_periph_ctrl;
    localparam int          TO  = 64;
    localparam logic [31:0] NAN = 32'h7FC00000;
`ifdef CORDIC_IRQ_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        user_interrupt, eng_cos, eng_start, eng_clk_en, eng_reset;
    logic        eng_done, eng_invalid;
    logic [31:0] eng_dataa, eng_result;

    always #5 clk = ~clk;

    cordic_periph_ctrl_if bif ();

    cordic_periph_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bif),
        .user_interrupt (user_interrupt),
        .eng_dataa      (eng_dataa),
        .eng_cos        (eng_cos),
        .eng_start      (eng_start),
        .eng_clk_en     (eng_clk_en),
        .eng_reset      (eng_reset),
        .eng_done       (eng_done),
        .eng_result     (eng_result),
        .eng_invalid    (eng_invalid)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: m_ph = -1 idle, 0 start cycle, k = k-th cycle spent waiting
    int          m_ph;
    logic [31:0] m_op, m_res;
    logic        m_done, m_inv, m_to, m_ov, m_cos, m_irqen, m_rst;

    always @(posedge clk or posedge reset) begin : model
        int          ph, old;
        logic [31:0] op, res;
        logic        dn, iv, tm, ov, cs, ie, rs, w, s;
        if (reset) begin
            m_ph <= -1; m_op <= '0; m_res <= '0;
            m_done <= 0; m_inv <= 0; m_to <= 0; m_ov <= 0;
            m_cos <= 0; m_irqen <= 0; m_rst <= 0;
        end else begin
            old = m_ph; ph = m_ph; op = m_op; res = m_res;
            dn = m_done; iv = m_inv; tm = m_to; ov = m_ov;
            cs = m_cos; ie = m_irqen; rs = 0;
            w = bif.data_write_n == 2'b10;
            s = w && bif.address == 6'h04 && bif.data_in[3];
            if (w && bif.address == 6'h00) begin
                if (old >= 0) ov = 1;
                else op = bif.data_in;
            end
            if (bif.data_read_n != 2'b11 && bif.address == 6'h0C) dn = 0;
            if (w && bif.address == 6'h04) begin
                if (IRQ) ie = bif.data_in[4];
                if (s) begin
                    dn = 0; iv = 0; tm = 0; ov = 0; rs = 1; ph = -1;
                end else begin
                    if (bif.data_in[2]) begin
                        dn = 0; iv = 0; tm = 0; ov = 0;
                    end
                    if (bif.data_in[0]) begin
                        if (old >= 0) ov = 1;
                        else begin
                            cs = bif.data_in[1]; dn = 0; iv = 0; tm = 0;
                            if (eng_invalid) begin
                                iv = 1; dn = 1; res = NAN;
                            end else ph = 0;
                        end
                    end
                end
            end
            if (!s) begin
                if (old == 0) ph = 1;
                else if (old >= 1) begin
                    if (eng_done) begin
                        res = eng_result; dn = 1; ph = -1;
                    end else if (old == TO) begin
                        tm = 1; rs = 1; ph = -1;
                    end else ph = old + 1;
                end
            end
            m_ph <= ph; m_op <= op; m_res <= res; m_done <= dn;
            m_inv <= iv; m_to <= tm; m_ov <= ov; m_cos <= cs;
            m_irqen <= ie; m_rst <= rs;
        end
    end

    function automatic logic [31:0] exp_rd(logic [5:0] a);
        logic b;
        b = (m_ph >= 0) ? 1'b1 : 1'b0;
        case (a)
            6'h00:   return m_op;
            6'h04:   return {27'b0, m_irqen, 2'b00, m_cos, 1'b0};
            6'h08:   return {27'b0, m_ov, m_to, m_inv, m_done, b};
            6'h0C:   return m_res;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            chk("data_out", bif.data_out, exp_rd(bif.address));
            chk("eng_start", {31'b0, eng_start}, {31'b0, m_ph == 0});
            chk("eng_reset", {31'b0, eng_reset}, {31'b0, m_rst});
            chk("eng_dataa", eng_dataa, m_op);
            chk("eng_cos", {31'b0, eng_cos}, {31'b0, m_cos});
            chk("irq", {31'b0, user_interrupt},
                {31'b0, m_done & m_irqen & IRQ});
            chk("consts", {30'b0, eng_clk_en, bif.data_ready}, 32'h3);
        end
    end

    int          cd = 0;
    int          stub_lat = 20;
    bit          rnd_mode = 0;
    logic [31:0] stub_val = 32'h3F3504F3;
    logic        inv_force = 0;
    int          starts = 0;
    int          rsts = 0;

    task automatic tick();
        @(negedge clk);
        bif.data_write_n = 2'b11;
        bif.data_read_n  = 2'b11;
        eng_done    = 1'b0;
        eng_result  = $urandom;
        eng_invalid = inv_force;
        if (eng_start) starts++;
        if (eng_reset) rsts++;
        if (reset || eng_reset) cd = 0;
        else if (eng_start) begin
            if (rnd_mode) begin
                case ($urandom_range(0, 5))
                    0:       stub_lat = 63;
                    1:       stub_lat = 64;
                    2:       stub_lat = 65;
                    3:       stub_lat = 0;
                    default: stub_lat = $urandom_range(1, 30);
                endcase
                stub_val = $urandom;
            end
            cd = stub_lat;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                eng_done   = 1'b1;
                eng_result = stub_val;
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic wr(logic [5:0] a, logic [31:0] v);
        tick();
        bif.address = a; bif.data_in = v; bif.data_write_n = 2'b10;
    endtask

    task automatic rd(logic [5:0] a);
        tick();
        bif.address = a; bif.data_read_n = 2'b00;
    endtask

    task automatic lit(logic [5:0] a, logic [31:0] e, string n);
        tick();
        bif.address = a;
        #1 chk(n, bif.data_out, e);
    endtask

    task automatic bit_at(logic act, logic e, string n);
        tick();
        #1 chk(n, {31'b0, act}, {31'b0, e});
    endtask

    initial begin
        int s0, r0, r;
        logic [31:0] v;
        bif.address = '0; bif.data_in = '0;
        bif.data_write_n = 2'b11; bif.data_read_n = 2'b11;
        eng_done = 0; eng_result = '0; eng_invalid = 0;
        idle(3);
        reset = 1'b0;

        lit(6'h08, 32'h0, "rst status");
        lit(6'h0C, 32'h0, "rst result");
        lit(6'h00, 32'h0, "rst operand");
        #1 chk("rst eng", {28'b0, eng_start, eng_reset, eng_cos,
                           user_interrupt}, 32'h0);

        // 1: normal sin request
        wr(6'h00, 32'h3F490FDB);
        s0 = starts;
        wr(6'h04, 32'h1);
        lit(6'h08, 32'h1, "t1 busy N+1");
        #1 chk("t1 start N+1", {31'b0, eng_start}, 32'h1);
        lit(6'h08, 32'h1, "t1 busy N+2");
        #1 chk("t1 start N+2", {31'b0, eng_start}, 32'h0);
        idle(22);
        lit(6'h08, 32'h2, "t1 status");
        lit(6'h0C, 32'h3F3504F3, "t1 result");
        lit(6'h00, 32'h3F490FDB, "t1 operand");
        rd(6'h0C);
        lit(6'h08, 32'h0, "t1 after read");
        chk("t1 starts", starts - s0, 32'd1);

        // 2: invalid operand
        inv_force = 1;
        s0 = starts;
        wr(6'h04, 32'h1);
        idle(3);
        inv_force = 0;
        lit(6'h08, 32'h6, "t2 status");
        lit(6'h0C, NAN, "t2 result");
        chk("t2 starts", starts - s0, 32'd0);

        // 3: engine never answers
        stub_lat = 0;
        wr(6'h04, 32'h1);
        r0 = rsts;
        idle(64);
        lit(6'h08, 32'h1, "t3 still busy");
        lit(6'h08, 32'h8, "t3 timeout");
        idle(2);
        chk("t3 eng_reset pulses", rsts - r0, 32'd1);
        lit(6'h0C, NAN, "t3 result kept");

        // 4: start while busy
        stub_lat = 20;
        s0 = starts;
        wr(6'h04, 32'h1);
        idle(2);
        wr(6'h04, 32'h1);
        idle(25);
        chk("t4 starts", starts - s0, 32'd1);
        lit(6'h08, 32'h12, "t4 overrun");
        wr(6'h04, 32'h4);
        lit(6'h08, 32'h0, "t4 clr");

        // 5: done coincides with RESULT read
        stub_lat = 0;
        wr(6'h04, 32'h1);
        idle(5);
        tick();
        eng_done = 1; eng_result = 32'h12345678;
        bif.address = 6'h0C; bif.data_read_n = 2'b00;
        lit(6'h08, 32'h2, "t5 done kept");
        lit(6'h0C, 32'h12345678, "t5 result");

        // 6: interrupt
        stub_lat = 20;
        wr(6'h04, 32'h11);
        idle(20);
        bit_at(user_interrupt, 1'b0, "t6 irq before");
        bit_at(user_interrupt, IRQ, "t6 irq after done");
        rd(6'h0C);
        bit_at(user_interrupt, 1'b0, "t6 irq after read");
        lit(6'h04, {27'b0, IRQ, 4'b0}, "t6 ctrl read");

        // async reset mid-wait
        wr(6'h04, 32'h1);
        idle(5);
        tick();
        reset = 1'b1;
        bif.address = 6'h08;
        #1 chk("arst status", bif.data_out, 32'h0);
        chk("arst start", {31'b0, eng_start}, 32'h0);
        tick();
        reset = 1'b0;

        rnd_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (i == 2000) reset = 1'b1;
            if (i == 2001) reset = 1'b0;
            eng_invalid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) bif.address = 6'($urandom);
            else bif.address = {2'b00, 2'($urandom), 2'b00};
            r = $urandom_range(0, 99);
            if (r < 6) begin
                bif.address = 6'h00; bif.data_in = $urandom;
                bif.data_write_n = 2'b10;
            end else if (r < 16) begin
                v = $urandom;
                v[0] = ($urandom_range(0, 2) != 0);
                v[2] = ($urandom_range(0, 5) == 0);
                v[3] = ($urandom_range(0, 19) == 0);
                bif.address = 6'h04; bif.data_in = v;
                bif.data_write_n = 2'b10;
            end else if (r < 30) begin
                bif.data_read_n = 2'($urandom_range(0, 2));
            end else if (r < 33) begin
                bif.data_in = $urandom;
                bif.data_write_n = 2'($urandom_range(0, 1));
            end else if (r < 35 && cd == 0) begin
                eng_done = 1'b1; eng_result = $urandom;
            end
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
